// File: rtl/reg8_scan_display_if.sv
// ---------------------------------------------------------------------------
// reg8_scan_display_if
// Bundles the display block's external signals: the register-file read port
// and the seven-segment board outputs.
//   q       : register-file read data (combinational function of rsel)
//   page    : 0 shows regs 0-3, 1 shows regs 4-7
//   freeze  : 1 skips snapshots and keeps the current shadow contents
//   rsel    : register-file read select
//   led_en  : digit enables, active-low, bit 7 = leftmost digit
//   led_seg : segments, active-low, {CA,CB,CC,CD,CE,CF,CG,DP}
// master = display block, slave = register file / board side.
// ---------------------------------------------------------------------------
interface reg8_scan_display_if;
  logic [7:0] q;
  logic       page;
  logic       freeze;
  logic [2:0] rsel;
  logic [7:0] led_en;
  logic [7:0] led_seg;

  modport master (
    input  q, page, freeze,
    output rsel, led_en, led_seg
  );

  modport slave (
    output q, page, freeze,
    input  rsel, led_en, led_seg
  );
endinterface

// File: rtl/reg8_scan_display.sv
// ---------------------------------------------------------------------------
// reg8_scan_display
// Snapshots the eight registers of an 8x8 register file into a shadow buffer,
// then time-multiplexes four of them as eight hex digits on a common-anode
// seven-segment display.
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : reg8_scan_display_if.master (q, page, freeze in; rsel, led_en,
//          led_seg out)
// Parameter SCAN_DIV: clock cycles each digit stays lit.
// ---------------------------------------------------------------------------
module reg8_scan_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                clr,
  reg8_scan_display_if.master bus
);

  localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned N_REGS  = 8;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [0:0] {
    ST_SNAP = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [2:0]       digit_q;
  logic [DIV_W-1:0] div_q;
  logic             page_lat_q;
  logic [7:0]       shadow_q [N_REGS];
  logic [7:0]       led_en_q;
  logic [7:0]       led_seg_q;

  logic [2:0]       sidx;
  logic [3:0]       nibble;
  logic [7:0]       led_en_d;
  logic [7:0]       led_seg_d;

  // Active-low hex glyphs, DP off.
  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Digit pairs 7/6, 5/4, 3/2, 1/0 map to base+0..3, so the offset is the
  // inverted pair number; odd digits carry the high nibble.
  always_comb begin
    sidx      = {page_lat_q, ~digit_q[2:1]};
    nibble    = digit_q[0] ? shadow_q[sidx][7:4] : shadow_q[sidx][3:0];
    led_en_d  = 8'hFF;
    led_seg_d = 8'hFF;
    if (state_q == ST_SCAN) begin
      led_en_d  = ~(8'(1) << digit_q);
      led_seg_d = hex_seg(nibble);
    end
  end

  // Snapshot/scan sequencer with one-cycle registered display outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_SNAP;
      idx_q      <= 3'd0;
      digit_q    <= 3'd0;
      div_q      <= '0;
      page_lat_q <= 1'b0;
      led_en_q   <= 8'hFF;
      led_seg_q  <= 8'hFF;
      for (int i = 0; i < int'(N_REGS); i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else begin
      led_en_q  <= led_en_d;
      led_seg_q <= led_seg_d;
      case (state_q)
        ST_SNAP: begin
          shadow_q[idx_q] <= bus.q;
          if (idx_q == 3'd7) begin
            // Index stays at 7 so rsel holds its last value during SCAN.
            state_q    <= ST_SCAN;
            digit_q    <= 3'd0;
            div_q      <= '0;
            page_lat_q <= bus.page;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        ST_SCAN: begin
          if (div_q == DIV_MAX) begin
            div_q <= '0;
            if (digit_q == 3'd7) begin
              // freeze is only sampled here, at the end of the last digit.
              if (bus.freeze) begin
                digit_q    <= 3'd0;
                page_lat_q <= bus.page;
              end else begin
                state_q <= ST_SNAP;
                idx_q   <= 3'd0;
              end
            end else begin
              digit_q <= digit_q + 3'd1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= ST_SNAP;
      endcase
    end
  end

  assign bus.rsel    = idx_q;
  assign bus.led_en  = led_en_q;
  assign bus.led_seg = led_seg_q;

endmodule

// File: tb/tb_reg8_scan_display.sv
// ---------------------------------------------------------------------------
// tb_reg8_scan_display
// Directed bench: a behavioural register file answers rsel, and each scenario
// task checks rsel stepping, blanking and the digit glyphs of whole frames.
// Expected frames are packed 64-bit words, digit 7 in the top byte.
// ---------------------------------------------------------------------------
module tb_reg8_scan_display;

  localparam int SCAN_DIV = 4;

  // Expected glyphs, written digit 7 .. digit 0.
  localparam logic [63:0] EXP_P0      = 64'h9F_25_0D_99_49_41_1F_01;
  localparam logic [63:0] EXP_P1      = 64'h09_11_C1_63_85_61_71_03;
  localparam logic [63:0] EXP_P0_R2FF = 64'h9F_25_0D_99_71_71_1F_01;
  localparam logic [63:0] EXP_NEW_P0  = 64'h03_9F_25_0D_99_49_41_1F;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] regs [8];
  int         tests_run    = 0;
  int         tests_failed = 0;

  reg8_scan_display_if bus();

  assign bus.q = regs[bus.rsel];

  reg8_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_regs(input logic [63:0] v);
    for (int i = 0; i < 8; i++) regs[i] = v[63-8*i -: 8];
  endtask

  // Waits for the start of digit 0 and records one full scan frame; errs
  // counts enable/order/stability problems, 1000 means no frame was seen.
  task automatic capture_frame(input int poke_cycle, input int poke_idx,
                               input logic [7:0] poke_val, input logic poke_page,
                               output logic [63:0] segs, output int errs,
                               output int waited);
    logic [7:0] prev;
    bit         found;
    int         d;
    segs   = '1;
    errs   = 0;
    waited = 0;
    found  = 0;
    prev   = bus.led_en;
    while (!found && waited < 200) begin
      @(negedge clk);
      waited++;
      if (bus.led_en == 8'hFE && prev != 8'hFE) found = 1;
      else prev = bus.led_en;
    end
    if (!found) begin
      errs = 1000;
    end else begin
      for (int c = 0; c < 8 * SCAN_DIV; c++) begin
        if (c > 0) @(negedge clk);
        d = c / SCAN_DIV;
        if (c == poke_cycle) begin
          regs[poke_idx] = poke_val;
          bus.page       = poke_page;
        end
        if (bus.led_en !== ~(8'd1 << d)) errs++;
        if (c % SCAN_DIV == 0) segs[8*d +: 8] = bus.led_seg;
        else if (bus.led_seg !== segs[8*d +: 8]) errs++;
      end
    end
  endtask

  task automatic test_reset();
    clr        = 1'b1;
    bus.page   = 1'b0;
    bus.freeze = 1'b0;
    load_regs(64'h12_34_56_78_9A_BC_DE_F0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.led_en !== 8'hFF) begin
      tests_failed++; $display("FAIL reset_led_en: got %h expected ff", bus.led_en);
    end
    tests_run++;
    if (bus.led_seg !== 8'hFF) begin
      tests_failed++; $display("FAIL reset_led_seg: got %h expected ff", bus.led_seg);
    end
    tests_run++;
    if (bus.rsel !== 3'd0) begin
      tests_failed++; $display("FAIL reset_rsel: got %0d expected 0", bus.rsel);
    end
  endtask

  task automatic test_snapshot_page0();
    logic [63:0] segs;
    int errs, waited;
    logic [2:0] exp_rsel;
    clr = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      exp_rsel = (n < 8) ? 3'(n) : 3'd7;
      tests_run++;
      if (bus.rsel !== exp_rsel) begin
        tests_failed++; $display("FAIL snap_rsel[%0d]: got %0d expected %0d", n, bus.rsel, exp_rsel);
      end
      tests_run++;
      if (bus.led_en !== 8'hFF) begin
        tests_failed++; $display("FAIL snap_blank[%0d]: got %h expected ff", n, bus.led_en);
      end
    end
    capture_frame(-1, 0, 8'h00, 1'b0, segs, errs, waited);
    tests_run++;
    if (waited !== 1) begin
      tests_failed++; $display("FAIL p0_start: got %0d expected 1", waited);
    end
    tests_run++;
    if (errs !== 0) begin
      tests_failed++; $display("FAIL p0_scan_errs: got %0d expected 0", errs);
    end
    for (int d = 0; d < 8; d++) begin
      tests_run++;
      if (segs[8*d +: 8] !== EXP_P0[8*d +: 8]) begin
        tests_failed++; $display("FAIL p0_digit%0d: got %h expected %h", d, segs[8*d +: 8], EXP_P0[8*d +: 8]);
      end
    end
  endtask

  task automatic test_page1();
    logic [63:0] segs;
    int errs, waited, nz;
    bus.page = 1'b1;
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.led_en !== 8'hFF || bus.led_seg !== 8'hFF) nz++;
    end
    tests_run++;
    if (nz !== 0) begin
      tests_failed++; $display("FAIL p1_blank: got %0d lit cycles expected 0", nz);
    end
    capture_frame(-1, 0, 8'h00, 1'b1, segs, errs, waited);
    bus.page = 1'b0;
    tests_run++;
    if (waited !== 1 || errs !== 0) begin
      tests_failed++; $display("FAIL p1_scan: got waited=%0d errs=%0d expected 1/0", waited, errs);
    end
    for (int d = 0; d < 8; d++) begin
      tests_run++;
      if (segs[8*d +: 8] !== EXP_P1[8*d +: 8]) begin
        tests_failed++; $display("FAIL p1_digit%0d: got %h expected %h", d, segs[8*d +: 8], EXP_P1[8*d +: 8]);
      end
    end
  endtask

  task automatic test_midframe_update();
    logic [63:0] segs;
    int errs, waited, nz;
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.led_en !== 8'hFF) nz++;
    end
    tests_run++;
    if (nz !== 0) begin
      tests_failed++; $display("FAIL mid_blank: got %0d lit cycles expected 0", nz);
    end
    // reg2 changes while digit 2 is lit; this frame must not see it.
    capture_frame(2 * SCAN_DIV, 2, 8'hFF, 1'b0, segs, errs, waited);
    tests_run++;
    if (segs !== EXP_P0 || errs !== 0) begin
      tests_failed++; $display("FAIL mid_same_frame: got %h errs=%0d expected %h", segs, errs, EXP_P0);
    end
    capture_frame(-1, 0, 8'h00, 1'b0, segs, errs, waited);
    tests_run++;
    if (waited !== 9 || errs !== 0) begin
      tests_failed++; $display("FAIL mid_next_timing: got waited=%0d errs=%0d expected 9/0", waited, errs);
    end
    tests_run++;
    if (segs !== EXP_P0_R2FF) begin
      tests_failed++; $display("FAIL mid_next_frame: got %h expected %h", segs, EXP_P0_R2FF);
    end
  endtask

  task automatic test_freeze();
    logic [63:0] segs;
    int errs, waited, nz;
    bus.freeze = 1'b1;
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.led_en !== 8'hFF) nz++;
    end
    tests_run++;
    if (nz !== 0 || bus.rsel !== 3'd7) begin
      tests_failed++; $display("FAIL frz_snap: got lit=%0d rsel=%0d expected 0/7", nz, bus.rsel);
    end
    load_regs(64'h01_23_45_67_89_AB_CD_EF);
    for (int f = 0; f < 3; f++) begin
      capture_frame(-1, 0, 8'h00, 1'b0, segs, errs, waited);
      tests_run++;
      if (waited !== 1 || errs !== 0) begin
        tests_failed++; $display("FAIL frz_frame%0d_timing: got waited=%0d errs=%0d expected 1/0", f, waited, errs);
      end
      tests_run++;
      if (segs !== EXP_P0_R2FF) begin
        tests_failed++; $display("FAIL frz_frame%0d: got %h expected %h", f, segs, EXP_P0_R2FF);
      end
      tests_run++;
      if (bus.rsel !== 3'd7) begin
        tests_failed++; $display("FAIL frz_rsel%0d: got %0d expected 7", f, bus.rsel);
      end
    end
    // The last wrap already saw freeze=1, so one more frozen frame follows.
    bus.freeze = 1'b0;
    capture_frame(-1, 0, 8'h00, 1'b0, segs, errs, waited);
    tests_run++;
    if (waited !== 1 || segs !== EXP_P0_R2FF) begin
      tests_failed++; $display("FAIL frz_release_frame: got waited=%0d %h expected 1 %h", waited, segs, EXP_P0_R2FF);
    end
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.led_en !== 8'hFF) nz++;
    end
    tests_run++;
    if (nz !== 0) begin
      tests_failed++; $display("FAIL frz_resnap: got %0d lit cycles expected 0", nz);
    end
    capture_frame(-1, 0, 8'h00, 1'b0, segs, errs, waited);
    tests_run++;
    if (waited !== 1 || errs !== 0 || segs !== EXP_NEW_P0) begin
      tests_failed++; $display("FAIL frz_new_frame: got %h waited=%0d errs=%0d expected %h", segs, waited, errs, EXP_NEW_P0);
    end
  endtask

  task automatic test_async_clear();
    logic [63:0] segs;
    int errs, waited;
    logic [2:0] exp_rsel;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.rsel !== 3'd4) begin
      tests_failed++; $display("FAIL clr_pre_rsel: got %0d expected 4", bus.rsel);
    end
    clr = 1'b1;
    #1;
    tests_run++;
    if (bus.rsel !== 3'd0 || bus.led_en !== 8'hFF || bus.led_seg !== 8'hFF) begin
      tests_failed++; $display("FAIL clr_snap_async: got rsel=%0d en=%h seg=%h expected 0/ff/ff", bus.rsel, bus.led_en, bus.led_seg);
    end
    load_regs(64'h12_34_56_78_9A_BC_DE_F0);
    @(negedge clk);
    clr = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      exp_rsel = (n < 8) ? 3'(n) : 3'd7;
      tests_run++;
      if (bus.rsel !== exp_rsel) begin
        tests_failed++; $display("FAIL clr_rsel[%0d]: got %0d expected %0d", n, bus.rsel, exp_rsel);
      end
    end
    capture_frame(-1, 0, 8'h00, 1'b0, segs, errs, waited);
    tests_run++;
    if (waited !== 1 || errs !== 0 || segs !== EXP_P0) begin
      tests_failed++; $display("FAIL clr_full_snap: got %h waited=%0d errs=%0d expected %h", segs, waited, errs, EXP_P0);
    end
    // Land in the middle of digit 0 and clear again.
    repeat (10) @(negedge clk);
    tests_run++;
    if (bus.led_en !== 8'hFE) begin
      tests_failed++; $display("FAIL clr_pre_scan: got %h expected fe", bus.led_en);
    end
    clr = 1'b1;
    #1;
    tests_run++;
    if (bus.led_en !== 8'hFF || bus.led_seg !== 8'hFF) begin
      tests_failed++; $display("FAIL clr_scan_async: got en=%h seg=%h expected ff/ff", bus.led_en, bus.led_seg);
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_page_toggle();
    logic [63:0] segs;
    int errs, waited, nz;
    // page flips while digit 3 is lit; takes effect only next frame.
    capture_frame(3 * SCAN_DIV, 0, 8'h12, 1'b1, segs, errs, waited);
    tests_run++;
    if (waited !== 9 || errs !== 0) begin
      tests_failed++; $display("FAIL tog_timing: got waited=%0d errs=%0d expected 9/0", waited, errs);
    end
    tests_run++;
    if (segs !== EXP_P0) begin
      tests_failed++; $display("FAIL tog_same_frame: got %h expected %h", segs, EXP_P0);
    end
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.led_en !== 8'hFF) nz++;
    end
    tests_run++;
    if (nz !== 0) begin
      tests_failed++; $display("FAIL tog_blank: got %0d lit cycles expected 0", nz);
    end
    capture_frame(-1, 0, 8'h00, 1'b1, segs, errs, waited);
    tests_run++;
    if (waited !== 1 || errs !== 0 || segs !== EXP_P1) begin
      tests_failed++; $display("FAIL tog_next_frame: got %h waited=%0d errs=%0d expected %h", segs, waited, errs, EXP_P1);
    end
    bus.page = 1'b0;
  endtask

  initial begin
    test_reset();
    test_snapshot_page0();
    test_page1();
    test_midframe_update();
    test_freeze();
    test_async_clear();
    test_page_toggle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
